// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction-fetch sequencer with stall hold and deferred redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          SQ_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [31:0]     instr_pc,
    output logic [SQ_W-1:0] squash_count
);
    typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;
    state_t      state, state_nx;
    logic [31:0] pc, pend_pc, tgt;
    logic        pend, redir;

    assign tgt   = redirect_pc & ~32'h3;
    assign redir = redirect_valid | pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = REQ;
            REQ:     state_nx = (imem_ack && !redir) ? VALID : REQ;
            VALID:   state_nx = (redirect_valid || !stall) ? REQ : VALID;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = state == REQ;
        instr_valid = state == VALID;
        imem_addr   = pc;
    end

    // A response that races a redirect (current or pending) is squashed, never presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            pend         <= 1'b0;
            pend_pc      <= 32'h0;
            instr        <= 32'h0;
            instr_pc     <= 32'h0;
            squash_count <= '0;
        end else begin
            case (state)
                IDLE: if (redirect_valid) pc <= tgt;
                REQ: begin
                    if (imem_ack && redir) begin
                        pc   <= redirect_valid ? tgt : pend_pc;
                        pend <= 1'b0;
                        if (squash_count != '1) squash_count <= squash_count + SQ_W'(1);
                    end else if (imem_ack) begin
                        instr    <= imem_rdata;
                        instr_pc <= pc;
                        pc       <= pc + 32'd4;
                    end else if (redirect_valid) begin
                        pend    <= 1'b1;
                        pend_pc <= tgt;
                    end
                end
                VALID: if (redirect_valid) pc <= tgt;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed test-plan scenarios plus random stimulus against a behavioural fetch model.
module tb_fetch_ctrl;
    logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect_valid = 1'b0, imem_ack = 1'b0;
    logic [31:0] redirect_pc = 32'h0, imem_rdata = 32'h0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;
    logic [7:0]  squash_count;
    int          total = 0, bad = 0;

    // model: phase 0 = waiting one cycle after reset, 1 = fetch outstanding, 2 = holding an instruction
    int          m_ph, m_sq;
    logic [31:0] m_pc, m_ipc, m_instr, m_ppc;
    logic        m_pend;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h100), .SQ_W(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .squash_count(squash_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_sq = 0; m_pc = 32'h100; m_ipc = 0; m_instr = 0; m_ppc = 0; m_pend = 0;
    endtask

    task automatic compare();
        check("req", 32'(imem_req), 32'(m_ph == 1));
        check("addr", imem_addr, m_pc);
        check("valid", 32'(instr_valid), 32'(m_ph == 2));
        check("instr", instr, m_instr);
        check("ipc", instr_pc, m_ipc);
        check("squash", 32'(squash_count), 32'(m_sq));
    endtask

    task automatic check_reset_vals();
        check("rst_req", 32'(imem_req), 0);
        check("rst_addr", imem_addr, 32'h100);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", instr, 0);
        check("rst_ipc", instr_pc, 0);
        check("rst_squash", 32'(squash_count), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; stall = 0; redirect_valid = 0; imem_ack = 0;
        #1 check_reset_vals();
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    // drive at a negedge, let the model follow the posedge, compare at the next negedge
    task automatic cyc(input logic st, input logic rv, input logic [31:0] rpc, input logic ack, input logic [31:0] rd);
        logic [31:0] t;
        stall = st; redirect_valid = rv; redirect_pc = rpc;
        imem_ack = ack && (m_ph == 1); imem_rdata = rd;
        @(posedge clk);
        t = rpc & ~32'h3;
        if (m_ph == 0) begin
            if (rv) m_pc = t;
            m_ph = 1;
        end else if (m_ph == 1) begin
            if (imem_ack && (rv || m_pend)) begin
                m_pc = rv ? t : m_ppc;
                m_pend = 0;
                m_sq = (m_sq < 255) ? m_sq + 1 : 255;
            end else if (imem_ack) begin
                m_instr = rd; m_ipc = m_pc; m_pc = m_pc + 4; m_ph = 2;
            end else if (rv) begin
                m_pend = 1; m_ppc = t;
            end
        end else begin
            if (rv) begin m_pc = t; m_ph = 1; end
            else if (!st) m_ph = 1;
        end
        @(negedge clk);
        compare();
    endtask

    initial begin
        do_reset();
        check("idle_req", 32'(imem_req), 0);
        // sequential fetch, ack every request cycle
        cyc(0, 0, 0, 1, 32'h11);
        check("seq_a0", imem_addr, 32'h100);
        cyc(0, 0, 0, 1, 32'h11);
        check("seq_ipc0", instr_pc, 32'h100);
        cyc(0, 0, 0, 1, 32'h22);
        check("seq_a1", imem_addr, 32'h104);
        cyc(0, 0, 0, 1, 32'h22);
        cyc(0, 0, 0, 1, 32'h33);
        check("seq_a2", imem_addr, 32'h108);
        // stall hold
        cyc(0, 0, 0, 1, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0);
            check("stall_instr", instr, 32'hDEADBEEF);
            check("stall_req", 32'(imem_req), 0);
        end
        cyc(0, 0, 0, 0, 0);
        check("stall_next", imem_addr, 32'h10C);
        // redirect during outstanding fetch
        cyc(0, 0, 0, 1, 32'h44);
        cyc(0, 1, 32'h200, 0, 0);
        check("rd_a", imem_addr, 32'h200);
        cyc(0, 1, 32'h400, 0, 0);
        cyc(0, 1, 32'h500, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("rd_hold", imem_addr, 32'h200);
        cyc(0, 0, 0, 1, 32'h55);
        check("rd_next", imem_addr, 32'h500);
        check("rd_sq", 32'(squash_count), 1);
        check("rd_valid", 32'(instr_valid), 0);
        // redirect coincident with ack, misaligned target
        cyc(0, 1, 32'h303, 1, 32'h66);
        check("co_valid", 32'(instr_valid), 0);
        check("co_addr", imem_addr, 32'h300);
        // redirect while VALID and stalled
        cyc(0, 0, 0, 1, 32'h77);
        cyc(1, 1, 32'h80, 0, 0);
        check("vs_valid", 32'(instr_valid), 0);
        check("vs_addr", imem_addr, 32'h80);
        check("vs_sq", 32'(squash_count), 2);
        // pc wrap
        cyc(0, 1, 32'hFFFF_FFFC, 1, 0);
        cyc(0, 0, 0, 1, 32'h88);
        check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);
        check("wrap_addr", imem_addr, 32'h0);
        // saturation
        for (int i = 0; i < 300; i++) cyc(0, 1, $urandom, 1, $urandom);
        check("sat", 32'(squash_count), 255);
        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 2) != 0, $urandom);
        // asynchronous reset mid-request
        while (m_ph != 1) cyc(0, 0, 0, 0, 0);
        #2 rst = 1;
        #1 check_reset_vals();
        model_reset();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 20; i++) cyc($urandom_range(0, 1) == 0, 0, 0, 1, $urandom);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
